// File: rtl/pipe_ctrl_if.sv
// Stall/flush controller bus: per-stage stall requests and writeback exception info in;
// stall vector, flush and the fetch redirect handshake out.
interface pipe_ctrl_if;
   logic        stallreq_if;
   logic        stallreq_id;
   logic        stallreq_ex;
   logic        stallreq_mem;
   logic [31:0] excepttype_i;
   logic [31:0] cp0_epc_i;
   logic        new_pc_ready;
   logic [7:0]  stall;
   logic        flush;
   logic [31:0] new_pc;
   logic        new_pc_valid;

   modport master (
      input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
      input  excepttype_i, cp0_epc_i, new_pc_ready,
      output stall, flush, new_pc, new_pc_valid
   );

   modport slave (
      output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
      output excepttype_i, cp0_epc_i, new_pc_ready,
      input  stall, flush, new_pc, new_pc_valid
   );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: merges stage stall requests into a nested stall vector and
// turns a writeback exception into a one-cycle flush plus a valid/ready fetch redirect.
module pipe_ctrl (
   input logic        clk,
   input logic        rst,
   pipe_ctrl_if.master bus
);
   localparam int unsigned StallBus  = 8;
   localparam logic [31:0] ExcEret   = 32'h0000_000e;
   localparam logic [31:0] ExcVector = 32'hBFC0_0380;

   typedef enum logic [0:0] {StRun, StRedir} state_e;

   state_e                state_q, state_d;
   logic [31:0]           new_pc_q, new_pc_d;
   logic [StallBus-1:0]   stall;
   logic                  flush;
   logic                  new_pc_valid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StRun;
         new_pc_q <= 32'h0;
      end else begin
         state_q  <= state_d;
         new_pc_q <= new_pc_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      new_pc_d     = new_pc_q;
      stall        = '0;
      flush        = 1'b0;
      new_pc_valid = 1'b0;
      unique case (state_q)
         StRun: begin
            if (bus.excepttype_i != 32'h0) begin
               // Flush overrides every stall request; stall stays zero this cycle.
               flush    = 1'b1;
               new_pc_d = (bus.excepttype_i == ExcEret) ? bus.cp0_epc_i : ExcVector;
               state_d  = StRedir;
            end else if (bus.stallreq_mem) begin
               stall = 8'b0111_1111;
            end else if (bus.stallreq_ex) begin
               stall = 8'b0001_1111;
            end else if (bus.stallreq_id) begin
               stall = 8'b0000_1111;
            end else if (bus.stallreq_if) begin
               stall = 8'b0000_0111;
            end
         end
         StRedir: begin
            new_pc_valid = 1'b1;
            stall        = 8'b0000_0011;
            if (bus.new_pc_ready) begin
               state_d = StRun;
            end
         end
         default: state_d = StRun;
      endcase
   end

   assign bus.stall        = stall;
   assign bus.flush        = flush;
   assign bus.new_pc       = new_pc_q;
   assign bus.new_pc_valid = new_pc_valid;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl: stall priority, exception/ERET redirect,
// ready backpressure, exception under stall and reset while redirecting.
module tb_pipe_ctrl;
   logic clk;
   logic rst;
   int   checks;
   int   errors;
   int   transfers;
   int   xfer_base;

   pipe_ctrl_if bus ();

   pipe_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // A transfer happens at the coming posedge when valid and ready are high mid-cycle.
   always @(negedge clk) begin
      if (!rst && bus.new_pc_valid && bus.new_pc_ready) transfers++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      transfers = 0;
      rst       = 1'b1;
      bus.stallreq_if  = 1'b0;
      bus.stallreq_id  = 1'b0;
      bus.stallreq_ex  = 1'b0;
      bus.stallreq_mem = 1'b0;
      bus.excepttype_i = 32'h0;
      bus.cp0_epc_i    = 32'h0;
      bus.new_pc_ready = 1'b0;
      #2;
      check("rst_stall", {24'h0, bus.stall}, 32'h00);
      check("rst_flush", {31'h0, bus.flush}, 32'h0);
      check("rst_new_pc", bus.new_pc, 32'h0);
      check("rst_valid", {31'h0, bus.new_pc_valid}, 32'h0);
      tick();
      rst = 1'b0;
      tick();

      // Request priority
      bus.stallreq_if = 1'b1; #1;
      check("prio_if", {24'h0, bus.stall}, 32'h07);
      bus.stallreq_if = 1'b0; bus.stallreq_id = 1'b1; #1;
      check("prio_id", {24'h0, bus.stall}, 32'h0F);
      bus.stallreq_id = 1'b0; bus.stallreq_ex = 1'b1; #1;
      check("prio_ex", {24'h0, bus.stall}, 32'h1F);
      bus.stallreq_ex = 1'b0; bus.stallreq_mem = 1'b1; #1;
      check("prio_mem", {24'h0, bus.stall}, 32'h7F);
      tick();
      bus.stallreq_if = 1'b1; bus.stallreq_id = 1'b1; bus.stallreq_ex = 1'b1; #1;
      check("prio_all", {24'h0, bus.stall}, 32'h7F);
      check("prio_all_flush", {31'h0, bus.flush}, 32'h0);
      tick();
      bus.stallreq_if = 1'b0; bus.stallreq_id = 1'b0;
      bus.stallreq_ex = 1'b0; bus.stallreq_mem = 1'b0; #1;
      check("prio_drop", {24'h0, bus.stall}, 32'h00);
      tick();

      // Syscall entry
      bus.excepttype_i = 32'h8; bus.new_pc_ready = 1'b1; #1;
      check("sys_flush", {31'h0, bus.flush}, 32'h1);
      check("sys_stall", {24'h0, bus.stall}, 32'h00);
      check("sys_valid_n", {31'h0, bus.new_pc_valid}, 32'h0);
      xfer_base = transfers;
      tick();
      bus.excepttype_i = 32'h0; #1;
      check("sys_new_pc", bus.new_pc, 32'hBFC0_0380);
      check("sys_valid", {31'h0, bus.new_pc_valid}, 32'h1);
      check("sys_redir_stall", {24'h0, bus.stall}, 32'h03);
      check("sys_redir_flush", {31'h0, bus.flush}, 32'h0);
      tick();
      check("sys_run_valid", {31'h0, bus.new_pc_valid}, 32'h0);
      check("sys_run_stall", {24'h0, bus.stall}, 32'h00);
      check("sys_hold_pc", bus.new_pc, 32'hBFC0_0380);
      check("sys_xfers", transfers - xfer_base, 32'd1);
      tick();

      // ERET
      bus.cp0_epc_i = 32'hBFC0_1234; bus.excepttype_i = 32'he; #1;
      check("eret_flush", {31'h0, bus.flush}, 32'h1);
      tick();
      bus.excepttype_i = 32'h0; #1;
      check("eret_new_pc", bus.new_pc, 32'hBFC0_1234);
      check("eret_valid", {31'h0, bus.new_pc_valid}, 32'h1);
      tick();
      check("eret_run", {31'h0, bus.new_pc_valid}, 32'h0);

      // Ready backpressure; requests and exceptions in REDIR are ignored
      bus.new_pc_ready = 1'b0; bus.excepttype_i = 32'hc; #1;
      xfer_base = transfers;
      tick();
      bus.excepttype_i = 32'h8; bus.stallreq_mem = 1'b1; bus.cp0_epc_i = 32'h1111_2222;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("bp_valid", {31'h0, bus.new_pc_valid}, 32'h1);
         check("bp_new_pc", bus.new_pc, 32'hBFC0_0380);
         check("bp_stall", {24'h0, bus.stall}, 32'h03);
         check("bp_flush", {31'h0, bus.flush}, 32'h0);
         tick();
      end
      bus.excepttype_i = 32'h0; bus.new_pc_ready = 1'b1; #1;
      check("bp_valid4", {31'h0, bus.new_pc_valid}, 32'h1);
      check("bp_stall4", {24'h0, bus.stall}, 32'h03);
      tick();
      check("bp_run_valid", {31'h0, bus.new_pc_valid}, 32'h0);
      check("bp_run_stall", {24'h0, bus.stall}, 32'h7F);
      check("bp_xfers", transfers - xfer_base, 32'd1);
      bus.stallreq_mem = 1'b0;
      tick();

      // Another ERET so the next vector target is distinguishable
      bus.cp0_epc_i = 32'h8000_1000; bus.excepttype_i = 32'he; #1;
      tick();
      bus.excepttype_i = 32'h0; #1;
      check("eret2_new_pc", bus.new_pc, 32'h8000_1000);
      tick();

      // Exception during memory stall
      bus.stallreq_mem = 1'b1; bus.excepttype_i = 32'h4; #1;
      check("memx_flush", {31'h0, bus.flush}, 32'h1);
      check("memx_stall", {24'h0, bus.stall}, 32'h00);
      tick();
      bus.excepttype_i = 32'h0; bus.stallreq_mem = 1'b0; #1;
      check("memx_new_pc", bus.new_pc, 32'hBFC0_0380);
      check("memx_valid", {31'h0, bus.new_pc_valid}, 32'h1);
      tick();
      check("memx_run", {31'h0, bus.new_pc_valid}, 32'h0);

      // Reset while redirecting
      bus.new_pc_ready = 1'b0; bus.excepttype_i = 32'h8; #1;
      tick();
      bus.excepttype_i = 32'h0; #1;
      check("rstr_valid_pre", {31'h0, bus.new_pc_valid}, 32'h1);
      rst = 1'b1; #1;
      check("rstr_valid", {31'h0, bus.new_pc_valid}, 32'h0);
      check("rstr_new_pc", bus.new_pc, 32'h0);
      check("rstr_stall", {24'h0, bus.stall}, 32'h00);
      tick();
      rst = 1'b0;
      tick();
      check("rstr_run_valid", {31'h0, bus.new_pc_valid}, 32'h0);
      check("rstr_run_stall", {24'h0, bus.stall}, 32'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline stall/flush controller for the 8-entry stall bus that sequences every pipeline register, wb included. It merges per-stage stall requests into a nested stall vector and turns exceptions and ERET reported at writeback into a one-cycle flush. It then redirects the fetch front end through a valid/ready handshake. It sits beside the five-stage datapath and drives `stall` and `flush` into every stage register.

## Interface
- No parameters; stall width is `StallBus` = 8 bits.
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-high reset
- stallreq_if  in  1  instruction SRAM not ready
- stallreq_id  in  1  load-use hazard
- stallreq_ex  in  1  multi-cycle divider busy
- stallreq_mem  in  1  data SRAM not ready
- excepttype_i  in  32  exception code of the instruction in wb (0 = none)
- cp0_epc_i  in  32  current EPC from CP0
- new_pc_ready  in  1  fetch stage accepts redirect
- stall  out  8  per-boundary hold; bit0 pc, 1 inst req, 2 if, 3 id, 4 ex, 5 mem req, 6 mem/wb, 7 wb
- flush  out  1  clear all pipeline registers
- new_pc  out  32  redirect target
- new_pc_valid  out  1  redirect offered to fetch

## Operation
- States: RUN, REDIR.
- Stall merge in RUN (highest request wins):
  - stallreq_mem -> 8'b0111_1111
  - else stallreq_ex -> 8'b0001_1111
  - else stallreq_id -> 8'b0000_1111
  - else stallreq_if -> 8'b0000_0111
  - else 8'h00
- A boundary with stall[k]=1 and stall[k+1]=0 injects a bubble downstream; stage registers do this, not this block.
- Exception entry in RUN with excepttype_i != 0:
  - flush=1 in the same cycle (combinational).
  - stall forced to 8'h00 in that cycle; flush overrides all stall requests.
  - Target latched at the clock edge ending the cycle:
    - excepttype_i == 32'h0000_000e (ERET) -> cp0_epc_i.
    - Any other nonzero code -> 32'hBFC0_0380.
  - Next state REDIR.
- REDIR:
  - new_pc_valid=1, new_pc holds the latched target.
  - stall=8'b0000_0011 (pc and inst request held); flush=0.
  - stallreq_* and excepttype_i are ignored.
  - new_pc_valid && new_pc_ready -> RUN at the next edge.
  - Otherwise remain in REDIR; new_pc stays stable.
- RUN: new_pc_valid=0; new_pc holds its last value.

## Timing
- Reset values, asynchronous and immediate: state RUN, new_pc=32'h0, new_pc_valid=0, flush=0, stall=8'h00.
- The stall vector is purely combinational from the stallreq_* inputs and the state; 0-cycle latency.
- Exception detected in cycle N: flush in N; new_pc_valid from N+1; earliest return to RUN at N+2 (ready high in N+1).
- A redirect is transferred on each edge where valid and ready are both high; exactly one transfer per exception.
- Exception concurrent with stallreq_mem or any other request: flush wins; stall=0 in cycle N.
- Exception and ERET never coincide; a nonzero code other than 0xe takes the general vector.
- Reset during REDIR: new_pc_valid drops immediately, state returns to RUN, and the latched target is cleared.
- new_pc_ready high while in RUN has no effect.

## Test plan
- Request priority:
  - Stimulus: stallreq_if, stallreq_id, stallreq_ex, stallreq_mem raised singly, then all together, in RUN.
  - Required: stall = 07, 0F, 1F, 7F singly; 7F together; drops to 00 the cycle the requests fall.
- Syscall entry:
  - Stimulus: excepttype_i=32'h8 for one cycle; new_pc_ready=1.
  - Required: flush=1 and stall=00 in cycle N; new_pc=BFC00380 with new_pc_valid=1 in N+1; RUN in N+2.
- ERET:
  - Stimulus: cp0_epc_i=32'hBFC0_1234, excepttype_i=32'he.
  - Required: new_pc=BFC01234 in N+1.
- Ready backpressure:
  - Stimulus: overflow (code 0xc); new_pc_ready held low for 3 cycles, then high.
  - Required: new_pc_valid=1 for 4 cycles with new_pc stable; stall=03 throughout; exactly one transfer; then RUN.
- Exception during memory stall:
  - Stimulus: stallreq_mem=1 and excepttype_i=32'h4 in the same cycle.
  - Required: flush=1, stall=00; REDIR follows with target BFC00380.
- Reset in REDIR:
  - Stimulus: rst asserted mid-cycle while new_pc_valid=1.
  - Required: new_pc_valid and new_pc drop to 0 before the next edge; RUN after rst falls.
